audio_pwm_out: RTL and testbench

Output stage directly downstream of the SVF/volume stage. Captures each unsigned 8-bit `sample_out` word and its `sample_valid` strobe into a one-deep pending buffer. Applies a click-free mute/unmute gain ramp and renders the result as a fixed-period 8-bit PWM bitstream on the chip's audio pin. It also reports upstream overruns and flags each sample consumed at a period boundary.

---
 rtl/audio_pwm_out.sv | 187 ++++++++++++++++++
 tb/tb_audio_pwm_out.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_out.sv
// -----------------------------------------------------------------------------
// audio_pwm_out
//
// Final audio output stage. Unsigned 8-bit samples (midscale 128 = silence)
// arrive from the filter/volume stage. Each one is held in a one-deep pending
// buffer and consumed at the next PWM period boundary. It is then scaled by a
// 0..16 gain that ramps smoothly on mute/unmute, and rendered as a
// fixed-period PWM bitstream for the audio pad.
//
// Parameters
//   CNT_W         PWM counter width; period = 2^CNT_W clocks (only 8 is
//                 supported, so that duty resolution matches the sample).
//
// Ports
//   clk           system clock, sole clock domain
//   rst           synchronous active-high reset
//   sample_in     [7:0] unsigned audio sample
//   sample_valid  one-cycle strobe qualifying sample_in
//   enable        level: 1 = play (ramp gain up), 0 = mute (ramp gain down)
//   pwm_out       registered PWM bit to the pad
//   sample_req    one-cycle pulse at a boundary that consumed a pending sample
//   overrun       one-cycle pulse when a pending sample is overwritten
//                 before it was consumed
//   muted         high while the gain state machine is in MUTED
// -----------------------------------------------------------------------------
module audio_pwm_out #(
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       enable,
    output logic       pwm_out,
    output logic       sample_req,
    output logic       overrun,
    output logic       muted
);

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        PLAY      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [4:0] G_MAX      = 5'd16;
    localparam logic [7:0] MIDSCALE   = 8'd128;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       duty_reg;
    logic [7:0]       cur_reg;
    logic [7:0]       pend_reg;
    logic             pend_full_reg;
    logic [4:0]       g_reg;
    state_t           state_reg;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic       boundary;
    logic [7:0] sel;
    logic [4:0] g_up;
    logic [4:0] g_dn;
    logic [4:0] g_next;
    state_t     state_next;
    logic [7:0] duty_next;

    // Gain scaling about midscale: 128 + floor((s - 128) * g / 16).
    // With g in 0..16 the shifted term stays within -128..127, so adding 128
    // modulo 256 yields the exact result in 0..255 without a clamp.
    function automatic logic [7:0] scale(input logic [7:0] s, input logic [4:0] g);
        logic signed [8:0]  diff;
        logic signed [14:0] prod;
        diff = $signed({1'b0, s}) - 9'sd128;
        prod = $signed({{6{diff[8]}}, diff}) * $signed({10'b0, g});
        return 8'(prod >>> 4) + MIDSCALE;
    endfunction

    always_comb begin
        boundary = (cnt_reg == {CNT_W{1'b1}});

        // A sample still pending at the boundary is the one about to become
        // current, so it is what the new duty must be computed from.
        sel = pend_full_reg ? pend_reg : cur_reg;

        // Saturating one-step neighbours of the current gain.
        g_up = (g_reg >= G_MAX) ? G_MAX : g_reg + 5'd1;
        g_dn = (g_reg == 5'd0)  ? 5'd0  : g_reg - 5'd1;

        // Gain FSM step. The enable value seen at the boundary picks both the
        // transition and the direction of this boundary's step, so a reversal
        // mid-ramp continues from the current gain without a pause.
        g_next     = g_reg;
        state_next = state_reg;
        case (state_reg)
            MUTED: begin
                if (enable) begin
                    g_next     = 5'd1;
                    state_next = RAMP_UP;
                end else begin
                    g_next     = 5'd0;
                    state_next = MUTED;
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (enable) begin
                    g_next     = g_up;
                    state_next = (g_up == G_MAX) ? PLAY : RAMP_UP;
                end else begin
                    g_next     = g_dn;
                    state_next = (g_dn == 5'd0) ? MUTED : RAMP_DOWN;
                end
            end
            PLAY: begin
                if (enable) begin
                    g_next     = G_MAX;
                    state_next = PLAY;
                end else begin
                    g_next     = G_MAX - 5'd1;
                    state_next = RAMP_DOWN;
                end
            end
            default: begin
                g_next     = 5'd0;
                state_next = MUTED;
            end
        endcase

        duty_next = scale(sel, g_next);
    end

    // -------------------------------------------------------------------------
    // Sequential logic: counter, pending buffer, gain FSM, PWM compare
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            duty_reg      <= MIDSCALE;
            cur_reg       <= MIDSCALE;
            pend_reg      <= MIDSCALE;
            pend_full_reg <= 1'b0;
            g_reg         <= 5'd0;
            state_reg     <= MUTED;
            pwm_out       <= 1'b0;
            sample_req    <= 1'b0;
            overrun       <= 1'b0;
            muted         <= 1'b1;
        end else begin
            cnt_reg    <= cnt_reg + 1'b1;
            // Compare uses the pre-edge counter and duty, so the pad bit lags
            // them by exactly one clock.
            pwm_out    <= (cnt_reg < CNT_W'(duty_reg));
            sample_req <= 1'b0;
            overrun    <= 1'b0;

            if (boundary) begin
                g_reg     <= g_next;
                state_reg <= state_next;
                muted     <= (state_next == MUTED);
                duty_reg  <= duty_next;

                if (pend_full_reg) begin
                    cur_reg    <= pend_reg;
                    sample_req <= 1'b1;
                end

                // A strobe on the boundary refills the buffer just vacated
                // (or fills an empty one); neither case is an overrun.
                if (sample_valid) begin
                    pend_reg      <= sample_in;
                    pend_full_reg <= 1'b1;
                end else begin
                    pend_full_reg <= 1'b0;
                end
            end else if (sample_valid) begin
                pend_reg      <= sample_in;
                pend_full_reg <= 1'b1;
                overrun       <= pend_full_reg;
            end
        end
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// -----------------------------------------------------------------------------
// Testbench for audio_pwm_out. Stimulus is applied one full PWM period at a
// time, aligned so that each period starts right after a boundary edge. The
// high-cycle count of pwm_out over a period equals the duty loaded at the
// boundary that began it, so each vector's expected next duty is queued and
// compared one period later.
// -----------------------------------------------------------------------------
module tb_audio_pwm_out;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       enable;
    logic       pwm_out;
    logic       sample_req;
    logic       overrun;
    logic       muted;

    always #5 clk = ~clk;

    audio_pwm_out #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .enable       (enable),
        .pwm_out      (pwm_out),
        .sample_req   (sample_req),
        .overrun      (overrun),
        .muted        (muted)
    );

    typedef struct {
        logic       en;
        int         p1;         // strobe position within period (-1 = none)
        logic [7:0] v1;
        int         p2;
        logic [7:0] v2;
        int         duty_next;  // duty expected after this period's boundary
        int         req;        // sample_req pulses expected in this period
        int         ovr;        // overrun pulses expected in this period
        int         mut;        // muted expected right after the boundary
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   both_hi = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic en, input int p1, input logic [7:0] v1,
                                input int p2, input logic [7:0] v2, input int duty_next,
                                input int req, input int ovr, input int mut,
                                input string name);
        vec_t v;
        v.en = en; v.p1 = p1; v.v1 = v1; v.p2 = p2; v.v2 = v2;
        v.duty_next = duty_next; v.req = req; v.ovr = ovr; v.mut = mut;
        v.name = name;
        vecs.push_back(v);
    endfunction

    // Drives one 256-cycle period starting just after a boundary edge and
    // ends just after the next boundary edge.
    task automatic run_period(input logic en, input int p1, input logic [7:0] v1,
                              input int p2, input logic [7:0] v2,
                              output int highs, output int reqs, output int ovrs);
        highs = 0; reqs = 0; ovrs = 0;
        for (int i = 0; i < 256; i++) begin
            enable       = en;
            sample_valid = (i == p1) || (i == p2);
            sample_in    = (i == p1) ? v1 : v2;
            @(posedge clk);
            #1;
            highs += int'(pwm_out);
            reqs  += int'(sample_req);
            ovrs  += int'(overrun);
            if (sample_req && overrun) both_hi++;
        end
        sample_valid = 1'b0;
    endtask

    task automatic pop_check(input string name, input int highs);
        int exp;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check({name, "_highs"}, highs, exp);
        end
    endtask

    initial begin
        int highs, reqs, ovrs;

        rst = 1'b1; sample_valid = 1'b0; sample_in = 8'd0; enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_sample_req", int'(sample_req), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_muted", int'(muted), 1);
        rst = 1'b0;

        // ---------------- vector table ----------------
        add(0, -1, 0, -1, 0, 128, 0, 0, 1, "idle0");
        add(0, -1, 0, -1, 0, 128, 0, 0, 1, "idle1");
        // Ramp up with a full-scale sample: duty = 128 + floor(127*g/16) = 127+8g
        for (int g = 1; g <= 16; g++)
            add(1, 10, 8'd255, -1, 0, 127 + 8 * g, 1, 0, 0, $sformatf("up_g%0d", g));
        // Two strobes in one period: overrun, newest (200) wins
        add(1, 20, 8'd10, 100, 8'd200, 200, 1, 1, 0, "overrun");
        // Strobe on the boundary with empty buffer: not consumed until next boundary
        add(1, 255, 8'd77, -1, 0, 200, 0, 0, 0, "bnd_empty");
        add(1, -1, 0, -1, 0, 77, 1, 0, 0, "bnd_empty_next");
        // Strobe on the boundary with full buffer: old consumed, new pending, no overrun
        add(1, 10, 8'd60, 255, 8'd180, 60, 1, 0, 0, "bnd_full");
        add(1, -1, 0, -1, 0, 180, 1, 0, 0, "bnd_full_next");
        // Zero sample at full gain, then ramp down: duty = 128 - 8g
        add(1, 10, 8'd0, -1, 0, 0, 1, 0, 0, "zero");
        for (int g = 15; g >= 0; g--)
            add(0, -1, 0, -1, 0, 128 - 8 * g, 0, 0, (g == 0) ? 1 : 0, $sformatf("down_g%0d", g));
        add(0, -1, 0, -1, 0, 128, 0, 0, 1, "muted_again");
        // Ramp up to g=7, then reverse
        add(1, 10, 8'd255, -1, 0, 135, 1, 0, 0, "rev_g1");
        for (int g = 2; g <= 7; g++)
            add(1, -1, 0, -1, 0, 127 + 8 * g, 0, 0, 0, $sformatf("rev_g%0d", g));
        for (int g = 6; g >= 4; g--)
            add(0, -1, 0, -1, 0, 127 + 8 * g, 0, 0, 0, $sformatf("rev_dn_g%0d", g));

        exp_q.push_back(128);   // duty loaded by reset
        foreach (vecs[k]) begin
            run_period(vecs[k].en, vecs[k].p1, vecs[k].v1, vecs[k].p2, vecs[k].v2,
                       highs, reqs, ovrs);
            $display("period %0d %s: highs=%0d req=%0d ovr=%0d muted=%0b",
                     k, vecs[k].name, highs, reqs, ovrs, muted);
            pop_check(vecs[k].name, highs);
            check({vecs[k].name, "_req"}, reqs, vecs[k].req);
            check({vecs[k].name, "_ovr"}, ovrs, vecs[k].ovr);
            check({vecs[k].name, "_muted"}, int'(muted), vecs[k].mut);
            exp_q.push_back(vecs[k].duty_next);
        end

        // ---------------- reset in the middle of a ramp ----------------
        run_period(0, -1, 0, -1, 0, highs, reqs, ovrs);
        $display("period ramp_g3: highs=%0d req=%0d ovr=%0d muted=%0b", highs, reqs, ovrs, muted);
        pop_check("ramp_g3", highs);
        check("ramp_g3_muted", int'(muted), 0);

        for (int i = 0; i < 100; i++) begin
            enable       = 1'b0;
            sample_valid = (i == 50);
            sample_in    = 8'd5;
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("mid_reset: pwm_out=%0b sample_req=%0b overrun=%0b muted=%0b",
                 pwm_out, sample_req, overrun, muted);
        check("midrst_pwm_out", int'(pwm_out), 0);
        check("midrst_sample_req", int'(sample_req), 0);
        check("midrst_overrun", int'(overrun), 0);
        check("midrst_muted", int'(muted), 1);
        rst = 1'b0;

        // Pending sample discarded, counter restarted, duty back to midscale.
        run_period(0, -1, 0, -1, 0, highs, reqs, ovrs);
        $display("period after_reset: highs=%0d req=%0d ovr=%0d muted=%0b", highs, reqs, ovrs, muted);
        check("after_reset_highs", highs, 128);
        check("after_reset_req", reqs, 0);
        check("after_reset_ovr", ovrs, 0);
        check("after_reset_muted", int'(muted), 1);

        check("req_ovr_both_high", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
